// File: rtl/vec_pkg.sv
// Shared vector layout constants and the arbiter state encoding.
package vec_pkg;

  localparam int unsigned VEC_ELEMS = 6;
  localparam int unsigned ELEM_W    = 32;
  localparam int unsigned VEC_W     = VEC_ELEMS * ELEM_W;

  localparam logic [2:0] LEN4 = 3'd4;
  localparam logic [2:0] LEN6 = 3'd6;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request after index last_i, wrapping.
module rr_priority_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 3
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    last_i,
  output logic              valid_o,
  output logic [NumReq-1:0] win_onehot_o,
  output logic [IdW-1:0]    win_idx_o
);

  int unsigned cand;

  always_comb begin
    valid_o      = 1'b0;
    win_onehot_o = '0;
    win_idx_o    = '0;
    cand         = 0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = (32'(last_i) + off) % NumReq;
      if (!valid_o && (((req_i >> cand) & NumReq'(1)) != '0)) begin
        valid_o      = 1'b1;
        win_onehot_o = NumReq'(1) << cand;
        win_idx_o    = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/vector_op_arbiter.sv
// Round-robin sequencer sharing one vector add/sub datapath among NUM_REQ requesters.
// Define VADD_TIMEOUT_EN to add a watchdog on the datapath start/done handshake.
module vector_op_arbiter
  import vec_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*3-1:0]   req_length,
  input  logic [NUM_REQ-1:0]     req_op,
  input  logic [NUM_REQ*VEC_W-1:0] req_a,
  input  logic [NUM_REQ*VEC_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [VEC_W-1:0]       resp_data,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   au_start,
  output logic [2:0]             au_length,
  output logic                   au_operation,
  output logic [VEC_W-1:0]       au_ain,
  output logic [VEC_W-1:0]       au_bin,
  input  logic [VEC_W-1:0]       au_cout,
  input  logic                   au_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 2)
  begin : g_bad_param
    $error("vector_op_arbiter: illegal parameter combination");
  end

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [VEC_W-1:0]    resp_data_q, resp_data_d;
  logic                au_start_q, au_start_d;
  logic [2:0]          au_length_q, au_length_d;
  logic                au_op_q, au_op_d;
  logic [VEC_W-1:0]    au_a_q, au_a_d, au_b_q, au_b_d;

  logic                pick_valid;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_idx;

  logic [2:0]          sel_len;
  logic                sel_op;
  logic [VEC_W-1:0]    sel_a, sel_b;

`ifdef VADD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            resp_err_q, resp_err_d;
`endif

  rr_priority_pick #(
    .NumReq (NUM_REQ),
    .IdW    (ID_W)
  ) u_pick (
    .req_i        (req),
    .last_i       (last_q),
    .valid_o      (pick_valid),
    .win_onehot_o (pick_onehot),
    .win_idx_o    (pick_idx)
  );

  always_comb begin
    sel_len = '0;
    sel_op  = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == ID_W'(k)) begin
        sel_len = req_length[k*3 +: 3];
        sel_op  = req_op[k];
        sel_a   = req_a[k*VEC_W +: VEC_W];
        sel_b   = req_b[k*VEC_W +: VEC_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = '0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    au_start_d   = au_start_q;
    au_length_d  = au_length_q;
    au_op_d      = au_op_q;
    au_a_d       = au_a_q;
    au_b_d       = au_b_q;
`ifdef VADD_TIMEOUT_EN
    resp_err_d   = 1'b0;
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d       = pick_onehot;
          last_d      = pick_idx;
          au_start_d  = 1'b1;
          // Anything other than 4 is run as a full 6-element vector.
          au_length_d = (sel_len == LEN4) ? LEN4 : LEN6;
          au_op_d     = sel_op;
          au_a_d      = sel_a;
          au_b_d      = sel_b;
          state_d     = StIssue;
`ifdef VADD_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef VADD_TIMEOUT_EN
        cnt_d   = cnt_q + CntW'(1);
`endif
      end
      StWait: begin
        if (au_done) begin
          resp_data_d  = au_cout;
          resp_id_d    = last_q;
          resp_valid_d = 1'b1;
          au_start_d   = 1'b0;
          state_d      = StDrain;
`ifdef VADD_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
`ifdef VADD_TIMEOUT_EN
        else if (cnt_q == CntMax) begin
          resp_err_d = 1'b1;
          resp_id_d  = last_q;
          au_start_d = 1'b0;
          state_d    = StDrain;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StDrain: begin
        if (!au_done) begin
          state_d = StIdle;
        end
`ifdef VADD_TIMEOUT_EN
        else if (cnt_q == CntMax) begin
          resp_err_d = 1'b1;
          resp_id_d  = last_q;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= ID_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      au_start_q   <= 1'b0;
      au_length_q  <= '0;
      au_op_q      <= 1'b0;
      au_a_q       <= '0;
      au_b_q       <= '0;
`ifdef VADD_TIMEOUT_EN
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      au_start_q   <= au_start_d;
      au_length_q  <= au_length_d;
      au_op_q      <= au_op_d;
      au_a_q       <= au_a_d;
      au_b_q       <= au_b_d;
`ifdef VADD_TIMEOUT_EN
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_data    = resp_data_q;
  assign busy         = (state_q != StIdle);
  assign au_start     = au_start_q;
  assign au_length    = au_length_q;
  assign au_operation = au_op_q;
  assign au_ain       = au_a_q;
  assign au_bin       = au_b_q;
`ifdef VADD_TIMEOUT_EN
  assign resp_err     = resp_err_q;
`else
  assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_vector_op_arbiter.sv
// Directed bench for vector_op_arbiter with a small 3-cycle-latency datapath model.
module tb_vector_op_arbiter;
  import vec_pkg::*;

  localparam int NR  = 4;
  localparam int IDW = 3;
  localparam int TO  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR-1:0]       req;
  logic [NR*3-1:0]     req_length;
  logic [NR-1:0]       req_op;
  logic [NR*VEC_W-1:0] req_a, req_b;
  logic [NR-1:0]       gnt;
  logic                resp_valid, resp_err, busy, au_start, au_operation, au_done;
  logic [IDW-1:0]      resp_id;
  logic [VEC_W-1:0]    resp_data, au_ain, au_bin, au_cout;
  logic [2:0]          au_length;
  logic [1:0]          dp_cnt;
  logic                dp_stuck;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int g_ids[$], g_cyc[$], r_ids[$], err_cyc[$], err_ids[$];
  logic [VEC_W-1:0] r_data[$];
  int viol_stab, viol_busy, viol_onehot, err_pulses;

  vector_op_arbiter #(
    .NUM_REQ        (NR),
    .ID_W           (IDW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_length   (req_length),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy),
    .au_start     (au_start),
    .au_length    (au_length),
    .au_operation (au_operation),
    .au_ain       (au_ain),
    .au_bin       (au_bin),
    .au_cout      (au_cout),
    .au_done      (au_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VEC_W-1:0] dp_calc(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                                               input logic [2:0] len, input logic op);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < VEC_ELEMS; i++) begin
      if (i < int'(len)) begin
        r[i*ELEM_W +: ELEM_W] = (op == OP_SUB) ? a[i*ELEM_W +: ELEM_W] - b[i*ELEM_W +: ELEM_W]
                                               : a[i*ELEM_W +: ELEM_W] + b[i*ELEM_W +: ELEM_W];
      end
    end
    return r;
  endfunction

  // Level handshake datapath: done rises 3 cycles into start, falls once start drops.
  always @(posedge clk) begin
    if (rst || !au_start) begin
      au_done <= 1'b0;
      dp_cnt  <= 2'd0;
    end else if (!au_done && !dp_stuck) begin
      if (dp_cnt == 2'd2) begin
        au_done <= 1'b1;
        au_cout <= dp_calc(au_ain, au_bin, au_length, au_operation);
      end else begin
        dp_cnt <= dp_cnt + 2'd1;
      end
    end
  end

  function automatic logic [VEC_W-1:0] qvec(input int e0, input int e1, input int e2,
                                            input int e3, input int e4, input int e5);
    int e[6];
    logic [VEC_W-1:0] r;
    e = '{e0, e1, e2, e3, e4, e5};
    r = '0;
    for (int i = 0; i < 6; i++) r[i*ELEM_W +: ELEM_W] = 32'(e[i] * 65536);
    return r;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [VEC_W-1:0] d_at(input int i);
    return (i < r_data.size()) ? r_data[i] : '1;
  endfunction

  task automatic set_slot(input int k, input logic [2:0] len, input logic op,
                          input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    req_length[k*3 +: 3] = len;
    req_op[k]            = op;
    req_a[k*VEC_W +: VEC_W] = a;
    req_b[k*VEC_W +: VEC_W] = b;
  endtask

  task automatic reset_mon();
    g_ids.delete(); g_cyc.delete(); r_ids.delete(); r_data.delete();
    err_cyc.delete(); err_ids.delete();
    viol_stab = 0; viol_busy = 0; viol_onehot = 0;
  endtask

  // Steps n cycles observing at negedge; drops granted req bits when asked and
  // clears all requests once max_g grants have been seen.
  task automatic run_cycles(input int n, input bit drop_on_gnt, input int max_g);
    logic [VEC_W-1:0] ha, hb;
    logic [2:0] hl;
    logic ho, held, prev_busy;
    held = 1'b0;
    prev_busy = busy;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (resp_err) begin
        err_pulses++;
        err_cyc.push_back(cyc);
        err_ids.push_back(int'(resp_id));
      end
      if (resp_valid) begin
        r_ids.push_back(int'(resp_id));
        r_data.push_back(resp_data);
      end
      if (gnt != '0) begin
        if (!$onehot(gnt)) viol_onehot++;
        if (prev_busy || !busy) viol_busy++;
        for (int k = 0; k < NR; k++) begin
          if (gnt[k]) begin
            g_ids.push_back(k);
            g_cyc.push_back(cyc);
            if (drop_on_gnt) req[k] = 1'b0;
          end
        end
        if (g_ids.size() >= max_g) req = '0;
        ha = au_ain; hb = au_bin; hl = au_length; ho = au_operation;
        held = 1'b1;
      end else if (busy) begin
        if (held && (au_ain !== ha || au_bin !== hb || au_length !== hl || au_operation !== ho))
          viol_stab++;
      end else begin
        held = 1'b0;
      end
      prev_busy = busy;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (au_start !== 1'b0) begin errors++; $display("FAIL rst_au_start: got %b want 0", au_start); end
    checks++; if (au_length !== 3'd0) begin errors++; $display("FAIL rst_au_length: got %0d want 0", au_length); end
    checks++; if (resp_id !== '0) begin errors++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
    checks++; if (resp_data !== '0 || au_ain !== '0 || au_bin !== '0)
      begin errors++; $display("FAIL rst_data: got %h want 0", resp_data); end
    req = 4'b1111;
    @(negedge clk);
    checks++; if (gnt !== '0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_no_grant: got gnt=%b busy=%b want 0 0", gnt, busy); end
    req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    reset_mon();
    set_slot(2, 3'd6, OP_ADD, qvec(1, 2, 3, 4, 5, 6), qvec(10, 20, 30, 40, 50, 60));
    req = 4'b0100;
    run_cycles(20, 1'b1, 1);
    checks++; if (g_ids.size() != 1 || q_at(g_ids, 0) != 2)
      begin errors++; $display("FAIL add_gnt: got n=%0d id=%0d want 1 2", g_ids.size(), q_at(g_ids, 0)); end
    checks++; if (r_ids.size() != 1 || q_at(r_ids, 0) != 2)
      begin errors++; $display("FAIL add_resp_id: got n=%0d id=%0d want 1 2", r_ids.size(), q_at(r_ids, 0)); end
    checks++; if (d_at(0) !== qvec(11, 22, 33, 44, 55, 66))
      begin errors++; $display("FAIL add_data: got %h want %h", d_at(0), qvec(11, 22, 33, 44, 55, 66)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_sub_len4();
    reset_mon();
    set_slot(1, 3'd4, OP_SUB, qvec(5, 5, 5, 5, 7, 7), qvec(1, 2, 3, 4, 9, 9));
    req = 4'b0010;
    run_cycles(20, 1'b1, 1);
    checks++; if (q_at(r_ids, 0) != 1 || r_ids.size() != 1)
      begin errors++; $display("FAIL sub_resp_id: got %0d want 1", q_at(r_ids, 0)); end
    checks++; if (d_at(0) !== qvec(4, 3, 2, 1, 0, 0))
      begin errors++; $display("FAIL sub_data: got %h want %h", d_at(0), qvec(4, 3, 2, 1, 0, 0)); end
    checks++; if (au_length !== 3'd4 || au_operation !== OP_SUB)
      begin errors++; $display("FAIL sub_au_cfg: got len=%0d op=%b want 4 1", au_length, au_operation); end
  endtask

  task automatic test_round_robin();
    int exp_v[4];
    exp_v = '{21, 19, 25, 19};
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    reset_mon();
    for (int k = 0; k < NR; k++)
      set_slot(k, 3'd6, k[0], qvec(20 + k, 20 + k, 20 + k, 20 + k, 20 + k, 20 + k),
               qvec(k + 1, k + 1, k + 1, k + 1, k + 1, k + 1));
    req = 4'b1111;
    run_cycles(70, 1'b0, 8);
    checks++; if (g_ids.size() != 8)
      begin errors++; $display("FAIL rr_count: got %0d want 8", g_ids.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (q_at(g_ids, i) != i % 4)
        begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, q_at(g_ids, i), i % 4); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (d_at(i) !== qvec(exp_v[i], exp_v[i], exp_v[i], exp_v[i], exp_v[i], exp_v[i]))
        begin errors++; $display("FAIL rr_data[%0d]: got %h", i, d_at(i)); end
    end
    checks++; if (r_ids.size() != 8 || q_at(r_ids, 7) != 3)
      begin errors++; $display("FAIL rr_resp: got n=%0d last=%0d want 8 3", r_ids.size(), q_at(r_ids, 7)); end
    checks++; if (viol_busy != 0 || viol_onehot != 0)
      begin errors++; $display("FAIL rr_gnt_timing: got %0d/%0d want 0/0", viol_busy, viol_onehot); end
    checks++; if (viol_stab != 0)
      begin errors++; $display("FAIL rr_operand_hold: got %0d changes want 0", viol_stab); end
  endtask

  task automatic test_mid_reset();
    bit seen;
    reset_mon();
    set_slot(0, 3'd6, OP_ADD, qvec(1, 1, 1, 1, 1, 1), qvec(2, 2, 2, 2, 2, 2));
    set_slot(1, 3'd6, OP_ADD, qvec(3, 3, 3, 3, 3, 3), qvec(4, 4, 4, 4, 4, 4));
    dp_stuck = 1'b1;
    req = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (gnt[1]) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mr_first_gnt: got none want gnt[1]"); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || au_start !== 1'b1)
      begin errors++; $display("FAIL mr_in_wait: got busy=%b start=%b want 1 1", busy, au_start); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (au_start !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 || gnt !== '0)
      begin errors++; $display("FAIL mr_abort: got start=%b busy=%b valid=%b gnt=%b want 0 0 0 0",
                               au_start, busy, resp_valid, gnt); end
    rst = 1'b0;
    dp_stuck = 1'b0;
    req = 4'b0011;
    run_cycles(30, 1'b1, 2);
    checks++; if (q_at(g_ids, 0) != 0 || q_at(g_ids, 1) != 1 || g_ids.size() != 2)
      begin errors++; $display("FAIL mr_regrant: got %0d,%0d want 0,1", q_at(g_ids, 0), q_at(g_ids, 1)); end
    checks++; if (r_ids.size() != 2 || q_at(r_ids, 0) != 0 || d_at(0) !== qvec(3, 3, 3, 3, 3, 3))
      begin errors++; $display("FAIL mr_resp: got n=%0d id=%0d want 2 0", r_ids.size(), q_at(r_ids, 0)); end
    checks++; if (d_at(1) !== qvec(7, 7, 7, 7, 7, 7))
      begin errors++; $display("FAIL mr_resp1_data: got %h", d_at(1)); end
  endtask

  task automatic test_illegal_len();
    bit seen;
    logic [2:0] len_seen;
    reset_mon();
    set_slot(2, 3'd5, OP_ADD, qvec(1, 2, 3, 4, 5, 6), qvec(1, 2, 3, 4, 5, 6));
    req = 4'b0100;
    run_cycles(20, 1'b1, 1);
    len_seen = au_length;
    seen = (q_at(g_ids, 0) == 2);
    checks++; if (!seen) begin errors++; $display("FAIL len5_gnt: got %0d want 2", q_at(g_ids, 0)); end
    checks++; if (len_seen !== 3'd6) begin errors++; $display("FAIL len5_au_length: got %0d want 6", len_seen); end
    checks++; if (d_at(0) !== qvec(2, 4, 6, 8, 10, 12))
      begin errors++; $display("FAIL len5_data: got %h want %h", d_at(0), qvec(2, 4, 6, 8, 10, 12)); end
  endtask

`ifdef VADD_TIMEOUT_EN
  task automatic test_timeout();
    reset_mon();
    dp_stuck = 1'b1;
    set_slot(3, 3'd6, OP_ADD, qvec(1, 1, 1, 1, 1, 1), qvec(1, 1, 1, 1, 1, 1));
    req = 4'b1000;
    run_cycles(25, 1'b1, 1);
    checks++; if (err_cyc.size() != 1 || g_cyc.size() != 1)
      begin errors++; $display("FAIL to_err_count: got %0d want 1", err_cyc.size()); end
    checks++; if (q_at(err_cyc, 0) - q_at(g_cyc, 0) != TO)
      begin errors++; $display("FAIL to_latency: got %0d want %0d", q_at(err_cyc, 0) - q_at(g_cyc, 0), TO); end
    checks++; if (q_at(err_ids, 0) != 3 || r_ids.size() != 0)
      begin errors++; $display("FAIL to_err_id: got id=%0d valid=%0d want 3 0", q_at(err_ids, 0), r_ids.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b want 0", busy); end
    reset_mon();
    dp_stuck = 1'b0;
    set_slot(0, 3'd6, OP_ADD, qvec(2, 2, 2, 2, 2, 2), qvec(3, 3, 3, 3, 3, 3));
    req = 4'b0001;
    run_cycles(15, 1'b1, 1);
    checks++; if (q_at(r_ids, 0) != 0 || d_at(0) !== qvec(5, 5, 5, 5, 5, 5))
      begin errors++; $display("FAIL to_recover: got id=%0d want 0", q_at(r_ids, 0)); end
  endtask
`else
  task automatic test_no_err();
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL no_err: got %0d pulses want 0", err_pulses); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = '0;
    req_length = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    dp_stuck = 1'b0;
    err_pulses = 0;
    reset_mon();
    test_reset();
    test_single_add();
    test_sub_len4();
    test_round_robin();
    test_mid_reset();
    test_illegal_len();
`ifdef VADD_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
